// File: rtl/add_share_arb.sv
// Four requesters share one 16-bit Brent-Kung adder through a round-robin arbiter
// feeding a one-entry result register with valid/ready handshakes on both sides.

module bkadder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);
    localparam int LVL = $clog2(W);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] p0;
    logic [W-1:0] carry;

    // NOTE: g/p are updated in place, so blocking assignments are required here;
    // each level only reads positions that the same level never writes.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        p0 = p;
        // up-sweep: build group (G,P) over power-of-two spans
        for (int d = 0; d < LVL; d++) begin
            for (int i = (2 << d) - 1; i < W; i += (2 << d)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                p[i] = p[i] & p[i - (1 << d)];
            end
        end
        // down-sweep: fill in the remaining prefixes
        for (int d = LVL - 2; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < W; i += (2 << d)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                p[i] = p[i] & p[i - (1 << d)];
            end
        end
        carry = {g[W-2:0], 1'b0};
        sum_o = p0 ^ carry;
    end
endmodule

module add_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [W-1:0]              res_sum,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic                      busy
);
    localparam int IDW = $clog2(NREQ);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state_q,  state_d;
    logic [W-1:0]   sum_q,    sum_d;
    logic [IDW-1:0] id_q,     id_d;
    logic [IDW-1:0] ptr_q,    ptr_d;

    logic           can_accept;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           handshake;
    logic [W-1:0]   a_lane [NREQ];
    logic [W-1:0]   b_lane [NREQ];
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   add_sum;

    assign res_valid  = (state_q == ST_FULL);
    assign busy       = res_valid;
    assign res_sum    = sum_q;
    assign res_id     = id_q;
    assign can_accept = !res_valid || res_ready;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[ptr_q + IDW'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = ptr_q + IDW'(k);
            end
        end
    end

    // Reset gates the accept so nothing can hand off while state is being cleared.
    always_comb begin
        req_ready = '0;
        if (!rst && can_accept && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign handshake = |req_ready;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_lane[i] = req_a[i*W +: W];
            b_lane[i] = req_b[i*W +: W];
        end
        a_sel = a_lane[grant_idx];
        b_sel = b_lane[grant_idx];
    end

    bkadder #(.W(W)) u_adder (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .sum_o (add_sum)
    );

    // A new result overrides a drain in the same cycle, so the register never bubbles.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (handshake) begin
            state_d = ST_FULL;
            sum_d   = add_sum;
            id_d    = grant_idx;
            ptr_d   = grant_idx + IDW'(1);
        end else if (state_q == ST_FULL && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            sum_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule
